bit_reverse_stream_reorder: RTL and testbench



---
 rtl/fft_pkg.sv | 18 +
 rtl/reorder_bank.sv | 33 +++
 rtl/bit_reverse_stream_reorder.sv | 105 ++++++++++
 tb/tb_bit_reverse_stream_reorder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and index helpers for the FFT datapath.
package fft_pkg;

    localparam int DEFAULT_N        = 8;
    localparam int DEFAULT_NUM_SIZE = 32;
    localparam int INDEX_SIZE       = $clog2(DEFAULT_N);

    // Mirrors the INDEX_SIZE-bit index: bit i of the result is bit (INDEX_SIZE-1-i) of the input.
    function automatic logic [INDEX_SIZE-1:0] bit_reverse(input logic [INDEX_SIZE-1:0] index);
        logic [INDEX_SIZE-1:0] result;
        result = '0;
        for (int i = 0; i < INDEX_SIZE; i++) begin
            result[i] = index[INDEX_SIZE-1-i];
        end
        return result;
    endfunction

endpackage

// File: rtl/reorder_bank.sv
// One frame of sample storage: single write port, asynchronous read port, synchronous clear.
module reorder_bank
    import fft_pkg::*;
#(
    parameter int DEPTH = DEFAULT_N,
    parameter int WIDTH = DEFAULT_NUM_SIZE,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the storage is cleared on reset so a discarded frame can never reappear on out_data.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bit_reverse_stream_reorder.sv
// Ping-pong reorder buffer: accepts bit-reversed-order frames, emits them in natural order.
module bit_reverse_stream_reorder
    import fft_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int NUM_SIZE = DEFAULT_NUM_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SIZE-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [NUM_SIZE-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last
);

    localparam int                IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [1:0]          full_q, full_d;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [IDX_W-1:0]    rd_cnt_q, rd_cnt_d;

    logic                in_fire;
    logic                out_fire;
    logic [IDX_W-1:0]    wr_addr;
    logic [NUM_SIZE-1:0] bank_rdata [2];

    // Width follows N here, so the mirror is wired directly rather than via the fixed-width helper.
    for (genvar b = 0; b < IDX_W; b++) begin : g_rev
        assign wr_addr[b] = wr_cnt_q[IDX_W-1-b];
    end

    assign in_ready  = !rst && !full_q[wr_bank_q];
    assign in_fire   = in_valid && in_ready;
    assign out_valid = full_q[rd_bank_q];
    assign out_fire  = out_valid && out_ready;
    assign out_data  = rd_bank_q ? bank_rdata[1] : bank_rdata[0];
    assign out_last  = out_valid && (rd_cnt_q == LAST_IDX);

    for (genvar k = 0; k < 2; k++) begin : g_bank
        reorder_bank #(
            .DEPTH (N),
            .WIDTH (NUM_SIZE),
            .AW    (IDX_W)
        ) u_bank (
            .clk     (clk),
            .clr_i   (rst),
            .we_i    (in_fire && (wr_bank_q == 1'(k))),
            .waddr_i (wr_addr),
            .wdata_i (in_data),
            .raddr_i (rd_cnt_q),
            .rdata_o (bank_rdata[k])
        );
    end

    // The writer only ever marks the bank it fills and the reader only clears the bank it drains,
    // so the two updates below never target the same flag in one cycle.
    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path leaves it unassigned.
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;

        if (in_fire) begin
            wr_cnt_d = wr_cnt_q + IDX_W'(1);
            if (wr_cnt_q == LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        if (out_fire) begin
            rd_cnt_d = rd_cnt_q + IDX_W'(1);
            if (rd_cnt_q == LAST_IDX) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

endmodule

// File: tb/tb_bit_reverse_stream_reorder.sv
// Scoreboard bench: randomized and directed frames checked against a natural-order frame model.
module tb_bit_reverse_stream_reorder;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [W-1:0] in_data, out_data;
    logic         in_valid, in_ready, out_valid, out_ready, out_last;
    logic [W-1:0] in_data16, out_data16;
    logic         in_valid16, in_ready16, out_valid16, out_ready16, out_last16;

    bit_reverse_stream_reorder #(.N(8), .NUM_SIZE(W)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    bit_reverse_stream_reorder #(.N(16), .NUM_SIZE(W)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data16),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .out_data  (out_data16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out_last  (out_last16)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    int           errors = 0;
    int           checks = 0;
    exp_t         exp8_q[$];
    exp_t         exp16_q[$];
    logic [W-1:0] frame8[$];
    logic [W-1:0] frame16[$];
    logic         rand_ready = 1'b0;
    int           last_waits;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain arithmetic bit reversal of an index over 'bits' bits.
    function automatic int rev(input int x, input int bits);
        int r = 0;
        for (int b = 0; b < bits; b++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    // Reference model: a complete frame, stored in arrival order, is emitted in natural order.
    // Arrival position k carries natural index rev(k), so natural index j sits at position rev(j).
    task automatic model_in(input logic [W-1:0] d, input int n, input int bits,
                            inout logic [W-1:0] frame[$], inout exp_t q[$]);
        frame.push_back(d);
        if (frame.size() == n) begin
            for (int j = 0; j < n; j++) begin
                q.push_back('{data: frame[rev(j, bits)], last: (j == n - 1)});
            end
            frame.delete();
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [W-1:0] d);
        int waits = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && waits < 200) begin
            step();
            waits++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: in_ready still 0 after %0d cycles", waits);
        end else begin
            model_in(d, 8, 3, frame8, exp8_q);
            step();
        end
        last_waits = waits;
    endtask

    task automatic drain8(input string name);
        int n = 0;
        in_valid = 1'b0;
        while (exp8_q.size() != 0 && n < 500) begin
            step();
            n++;
        end
        check(name, W'(exp8_q.size()), 0);
    endtask

    // Monitor for the N=8 instance: scoreboard pops plus hold-during-stall checks.
    logic [W-1:0] held_data;
    logic         held_last;
    logic         stalled = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, held_data);
                check("stall_last", out_last, held_last);
            end
            if (out_valid && out_ready) begin
                if (exp8_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_output: got 0x%0h, expected nothing", out_data);
                end else begin
                    e = exp8_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                end
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
        end
    end

    // Monitor for the N=16 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid16 && out_ready16) begin
            if (exp16_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_output16: got 0x%0h, expected nothing", out_data16);
            end else begin
                e = exp16_q.pop_front();
                check("out_data16", out_data16, e.data);
                check("out_last16", out_last16, e.last);
            end
        end
    end

    initial begin
        logic [W-1:0] vec [8];
        int bubbles;
        int total_waits;
        int accepted;
        int n;

        vec = '{32'h10, 32'h14, 32'h12, 32'h16, 32'h11, 32'h15, 32'h13, 32'h17};
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid16 = 1'b0; in_data16 = '0; out_ready16 = 1'b1;

        // Reset state
        repeat (3) step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // Single directed frame with latency check
        for (int k = 0; k < 8; k++) begin
            if (k == 7) check("pre_last_out_valid", out_valid, 1'b0);
            send(vec[k]);
        end
        check("latency_out_valid", out_valid, 1'b1);
        check("latency_out_data", out_data, 32'h10);
        drain8("single_drained");

        // Four back-to-back frames, no bubbles
        bubbles = 0;
        total_waits = 0;
        for (int i = 0; i < 32; i++) begin
            send($urandom);
            total_waits += last_waits;
            if (i >= 7 && !out_valid) bubbles++;
        end
        check("b2b_in_stalls", W'(total_waits), 0);
        check("b2b_out_bubbles", W'(bubbles), 0);
        drain8("b2b_drained");

        // Output stall for 20 cycles while input streams
        out_ready = 1'b0;
        accepted = 0;
        in_data = $urandom;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            if (in_ready) begin
                model_in(in_data, 8, 3, frame8, exp8_q);
                accepted++;
                step();
                in_data = $urandom;
            end else begin
                step();
            end
        end
        check("stall_accepted", W'(accepted), 16);
        check("stall_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain8("stall_drained");

        // Random in_valid and out_ready
        rand_ready = 1'b1;
        for (int i = 0; i < 48; i++) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                step();
            end
            send($urandom);
        end
        drain8("random_drained");
        rand_ready = 1'b0;
        out_ready = 1'b1;
        step();

        // Reset with frame 1 partly drained and frame 2 partly written
        for (int k = 0; k < 13; k++) send($urandom);
        in_valid = 1'b0;
        rst = 1'b1;
        frame8.delete();
        exp8_q.delete();
        step();
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) send(W'(32'h20 + rev(k, 3)));
        check("fresh_first_data", out_data, 32'h20);
        drain8("fresh_drained");

        // N=16 instance: bit-reversed feed of 0..15
        for (int k = 0; k < 16; k++) begin
            in_valid16 = 1'b1;
            in_data16  = W'(rev(k, 4));
            check("n16_in_ready", in_ready16, 1'b1);
            model_in(in_data16, 16, 4, frame16, exp16_q);
            step();
        end
        in_valid16 = 1'b0;
        n = 0;
        while (exp16_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check("n16_drained", W'(exp16_q.size()), 0);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
